// File: rtl/comp_seq.sv
// comp_seq: multi-cycle magnitude comparator, MSB-first, DIGIT bits/clock.
// Unsigned or two's-complement; early exit on the first differing slice.
module comp_seq #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_gt_B,
   output logic             A_lt_B,
   output logic             A_eq_B
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;

   logic [DIGIT-1:0] slice_a;
   logic [DIGIT-1:0] slice_b;
   logic             last_slice;
   logic [WIDTH-1:0] msb_flip;

   // Inverting both sign bits maps signed order onto unsigned order.
   assign msb_flip   = {signed_mode, {(WIDTH-1){1'b0}}};
   assign slice_a    = a_q[WIDTH-1 -: DIGIT];
   assign slice_b    = b_q[WIDTH-1 -: DIGIT];
   assign last_slice = (cnt_q == CW'(N - 1));

   // Next-state: accept in IDLE, scan one slice per cycle in RUN.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      gt_d    = gt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A ^ msb_flip;
               b_d     = B ^ msb_flip;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (slice_a != slice_b) begin
               gt_d    = (slice_a > slice_b);
               lt_d    = (slice_a < slice_b);
               eq_d    = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else if (last_slice) begin
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               eq_d    = 1'b1;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               a_d   = a_q << DIGIT;
               b_d   = b_q << DIGIT;
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and result registers; reset aborts any run and clears flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   assign busy   = (state_q == S_RUN);
   assign done   = done_q;
   assign A_gt_B = gt_q;
   assign A_lt_B = lt_q;
   assign A_eq_B = eq_q;

endmodule
